// File: rtl/system_nios2_gen2_0_cpu_debug_scan_master.sv
// Virtual-JTAG scan master: plays UIR, CDR, DR_LEN-bit SDR and E1DR into the debug slave.
// Define SCAN_MASTER_RSP_CAPTURE_EN to return sampled tdo/ir_out; otherwise responses read 0.
module system_nios2_gen2_0_cpu_debug_scan_master #(
    parameter int TCK_DIV = 2,
    parameter int DR_LEN  = 38
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_ir,
    input  logic [DR_LEN-1:0] cmd_dr,
    output logic              rsp_valid,
    output logic [DR_LEN-1:0] rsp_dr,
    output logic [1:0]        rsp_ir_out,
    output logic              vji_tck,
    output logic              vji_tdi,
    output logic              vji_rti,
    output logic              vji_uir,
    output logic              vji_cdr,
    output logic              vji_sdr,
    output logic              vji_e1dr,
    output logic [1:0]        vji_ir_in,
    input  logic              vji_tdo,
    input  logic [1:0]        vji_ir_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_E1DR
    } state_t;

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
    localparam int BIT_W = (DR_LEN > 2) ? $clog2(DR_LEN) : 1;
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_LEN - 1);

    state_t            state, state_d;
    logic [DIV_W-1:0]  div_cnt, div_d;
    logic [BIT_W-1:0]  bit_cnt, bit_d;
    logic [DR_LEN-1:0] shift_reg, shift_d;
    logic              tck_d, tdi_d, rsp_valid_d;
    logic              accept, period_end, rise_cycle, shift_in;

    assign accept     = cmd_valid && (state == S_IDLE);
    assign period_end = (state != S_IDLE) && (div_cnt == DIV_LAST);
    assign rise_cycle = (state != S_IDLE) && (div_cnt == DIV_RISE);

`ifdef SCAN_MASTER_RSP_CAPTURE_EN
    logic       tdo_cap;
    logic [1:0] ir_cap;

    // With TCK_DIV=1 the rise cycle is also the period end, so tdo is taken directly then.
    assign shift_in = rise_cycle ? vji_tdo : tdo_cap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tdo_cap    <= 1'b0;
            ir_cap     <= 2'b00;
            rsp_dr     <= '0;
            rsp_ir_out <= 2'b00;
        end else begin
            if (rise_cycle && (state == S_SDR)) tdo_cap <= vji_tdo;
            if (rise_cycle && (state == S_UIR)) ir_cap  <= vji_ir_out;
            if (rsp_valid_d) begin
                rsp_dr     <= shift_reg;
                rsp_ir_out <= ir_cap;
            end
        end
    end
`else
    logic unused_inputs;

    assign shift_in      = 1'b0;
    assign unused_inputs = ^{vji_tdo, vji_ir_out};
    assign rsp_dr        = '0;
    assign rsp_ir_out    = 2'b00;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        state_d     = state;
        div_d       = div_cnt;
        bit_d       = bit_cnt;
        shift_d     = shift_reg;
        rsp_valid_d = 1'b0;

        if (state == S_IDLE) begin
            if (accept) begin
                state_d = S_UIR;
                div_d   = '0;
                bit_d   = '0;
                shift_d = cmd_dr;
            end
        end else if (period_end) begin
            div_d = '0;
            case (state)
                S_UIR: state_d = S_CDR;
                S_CDR: state_d = S_SDR;
                S_SDR: begin
                    shift_d = {shift_in, shift_reg[DR_LEN-1:1]};
                    if (bit_cnt == BIT_LAST) state_d = S_E1DR;
                    else                     bit_d   = bit_cnt + BIT_W'(1);
                end
                S_E1DR: begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            div_d = div_cnt + DIV_W'(1);
        end

        // tck/tdi are registered from next-state values so the slave sees clean edges.
        tck_d = (state_d != S_IDLE) && (div_d >= DIV_RISE);
        tdi_d = (state_d == S_SDR) && shift_d[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the shift register is datapath, yet it is cleared so tdi and responses start known.
        if (!reset_n) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            vji_ir_in <= 2'b00;
            vji_tck   <= 1'b0;
            vji_tdi   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            state     <= state_d;
            div_cnt   <= div_d;
            bit_cnt   <= bit_d;
            shift_reg <= shift_d;
            vji_tck   <= tck_d;
            vji_tdi   <= tdi_d;
            rsp_valid <= rsp_valid_d;
            if (accept) vji_ir_in <= cmd_ir;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign vji_rti   = (state == S_IDLE);
    assign vji_uir   = (state == S_UIR);
    assign vji_cdr   = (state == S_CDR);
    assign vji_sdr   = (state == S_SDR);
    assign vji_e1dr  = (state == S_E1DR);

endmodule

// File: tb/tb_system_nios2_gen2_0_cpu_debug_scan_master.sv
// Randomized bench for the scan master: a default-parameter instance and a TCK_DIV=1/DR_LEN=2
// instance, checked cycle by cycle against a timing model derived from the scan rules.
module tb_system_nios2_gen2_0_cpu_debug_scan_master;

    localparam int TD_A = 2;
    localparam int DL_A = 38;
    localparam int TD_B = 1;
    localparam int DL_B = 2;

`ifdef SCAN_MASTER_RSP_CAPTURE_EN
    localparam bit CAPTURE = 1'b1;
`else
    localparam bit CAPTURE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel_b = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_ir = 2'b00;
    logic [37:0] cmd_dr = '0;
    logic        tdo_loop = 1'b0;
    logic        tdo_drv = 1'b0;
    logic [1:0]  ir_out_drv = 2'b00;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  q_ir[$];
    logic [37:0] q_dr[$];

    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        cmd_ready_a, rsp_valid_a, tck_a, tdi_a, rti_a, uir_a, cdr_a, sdr_a, e1dr_a, tdo_a;
    logic [37:0] rsp_dr_a;
    logic [1:0]  rsp_ir_out_a, ir_in_a;
    logic        cmd_valid_a;

    assign cmd_valid_a = cmd_valid & ~sel_b;
    assign tdo_a       = tdo_loop ? tdi_a : tdo_drv;

    system_nios2_gen2_0_cpu_debug_scan_master #(.TCK_DIV(TD_A), .DR_LEN(DL_A)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid_a), .rsp_dr(rsp_dr_a), .rsp_ir_out(rsp_ir_out_a),
        .vji_tck(tck_a), .vji_tdi(tdi_a), .vji_rti(rti_a), .vji_uir(uir_a), .vji_cdr(cdr_a),
        .vji_sdr(sdr_a), .vji_e1dr(e1dr_a), .vji_ir_in(ir_in_a),
        .vji_tdo(tdo_a), .vji_ir_out(ir_out_drv)
    );

    // Instance B: fastest tck, shortest DR
    logic        cmd_ready_b, rsp_valid_b, tck_b, tdi_b, rti_b, uir_b, cdr_b, sdr_b, e1dr_b, tdo_b;
    logic [1:0]  rsp_dr_b;
    logic [1:0]  rsp_ir_out_b, ir_in_b;
    logic        cmd_valid_b;

    assign cmd_valid_b = cmd_valid & sel_b;
    assign tdo_b       = tdo_loop ? tdi_b : tdo_drv;

    system_nios2_gen2_0_cpu_debug_scan_master #(.TCK_DIV(TD_B), .DR_LEN(DL_B)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr[1:0]),
        .rsp_valid(rsp_valid_b), .rsp_dr(rsp_dr_b), .rsp_ir_out(rsp_ir_out_b),
        .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_rti(rti_b), .vji_uir(uir_b), .vji_cdr(cdr_b),
        .vji_sdr(sdr_b), .vji_e1dr(e1dr_b), .vji_ir_in(ir_in_b),
        .vji_tdo(tdo_b), .vji_ir_out(ir_out_drv)
    );

    // Observed bundle: {cmd_ready, rsp_valid, rti, uir, cdr, sdr, e1dr, tck, tdi}
    logic [8:0]  flags;
    logic [37:0] obs_dr;
    logic [1:0]  obs_ir_out, obs_ir_in;

    assign flags = sel_b
        ? {cmd_ready_b, rsp_valid_b, rti_b, uir_b, cdr_b, sdr_b, e1dr_b, tck_b, tdi_b}
        : {cmd_ready_a, rsp_valid_a, rti_a, uir_a, cdr_a, sdr_a, e1dr_a, tck_a, tdi_a};
    assign obs_dr     = sel_b ? {36'b0, rsp_dr_b} : rsp_dr_a;
    assign obs_ir_out = sel_b ? rsp_ir_out_b : rsp_ir_out_a;
    assign obs_ir_in  = sel_b ? ir_in_b : ir_in_a;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected output bundle for cycle k after the accept cycle (k=0), from the scan rules:
    // one tck period per UIR/CDR/E1DR, dl periods of SDR, tck high in the second half-period.
    function automatic logic [8:0] exp_flags(input int k, input int lat, input int td,
                                             input int dl, input logic [37:0] dr);
        int   p, ph;
        logic in_sdr, bit_out;
        if (k >= lat) return 9'b1_1_1_0000_0_0;
        p       = (k - 1) / (2 * td);
        ph      = (k - 1) % (2 * td);
        in_sdr  = (p >= 2) && (p < 2 + dl);
        bit_out = 1'b0;
        if (in_sdr) bit_out = dr[p-2];
        return {1'b0, 1'b0, 1'b0, p == 0, p == 1, in_sdr, p == 2 + dl, ph >= td, bit_out};
    endfunction

    // Runs every queued command on the selected instance. tdo_mode: 0 loopback, 1 tied high, 2 random.
    task automatic run_scans(input bit b2b, input bit noise, input int tdo_mode);
        int          td, dl, lat, first_rsp, rises, sdr_rises;
        logic [37:0] mask, dr, exp_dr;
        logic [1:0]  ir;
        logic        prev_tck;
        bit          presented;
        td        = sel_b ? TD_B : TD_A;
        dl        = sel_b ? DL_B : DL_A;
        lat       = 1 + (dl + 3) * 2 * td;
        mask      = sel_b ? 38'h3 : {38{1'b1}};
        presented = 1'b0;
        tdo_loop  = (tdo_mode == 0);
        tdo_drv   = (tdo_mode == 1);
        while (q_ir.size() > 0) begin
            ir        = q_ir.pop_front();
            dr        = q_dr.pop_front() & mask;
            exp_dr    = (tdo_mode == 0) ? dr : (tdo_mode == 1) ? mask : '0;
            first_rsp = -1;
            rises     = 0;
            sdr_rises = 0;
            prev_tck  = 1'b0;
            if (!presented) begin
                @(negedge clk);
                check("ready_before_accept", 64'(flags[8]), 64'd1);
                cmd_valid = 1'b1;
                cmd_ir    = ir;
                cmd_dr    = dr;
            end
            presented = 1'b0;
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                check($sformatf("flags@%0d", k), 64'(flags), 64'(exp_flags(k, lat, td, dl, dr)));
                if (flags[7] && first_rsp < 0) first_rsp = k;
                if (flags[1] && !prev_tck) begin
                    rises++;
                    if (flags[3]) begin
                        sdr_rises++;
                        if (tdo_mode == 2 && sdr_rises <= dl) exp_dr[sdr_rises-1] = tdo_drv;
                    end
                end
                prev_tck = flags[1];
                if (tdo_mode == 2 && !flags[1]) tdo_drv = 1'($urandom);
                if (k == lat && b2b && q_ir.size() > 0) begin
                    cmd_valid = 1'b1;
                    cmd_ir    = q_ir[0];
                    cmd_dr    = q_dr[0] & mask;
                    presented = 1'b1;
                end else if (noise && k < lat) begin
                    cmd_valid = 1'($urandom);
                    cmd_ir    = 2'($urandom);
                    cmd_dr    = {6'($urandom), $urandom};
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            check("latency", 64'(first_rsp), 64'(lat));
            check("rsp_dr", 64'(obs_dr), CAPTURE ? 64'(exp_dr) : 64'd0);
            check("rsp_ir_out", 64'(obs_ir_out), CAPTURE ? 64'(ir_out_drv) : 64'd0);
            check("vji_ir_in", 64'(obs_ir_in), 64'(ir));
            check("tck_rises", 64'(rises), 64'(dl + 3));
            check("sdr_rises", 64'(sdr_rises), 64'(dl));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_flags"}, 64'(flags), 64'(9'b1_0_1_0000_0_0));
        check({tag, "_rsp_dr"}, 64'(obs_dr), 64'd0);
        check({tag, "_rsp_ir_out"}, 64'(obs_ir_out), 64'd0);
        check({tag, "_ir_in"}, 64'(obs_ir_in), 64'd0);
    endtask

    initial begin
        int rsp_seen;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        // Directed loopback pattern
        ir_out_drv = 2'b11;
        q_ir.push_back(2'b01);
        q_dr.push_back(38'h2A_5555_AAAA);
        run_scans(1'b0, 1'b0, 0);
        check("loopback_dr", 64'(obs_dr), CAPTURE ? 64'(38'h2A_5555_AAAA) : 64'd0);

        // tdo tied high, ir_out = 2'b10
        ir_out_drv = 2'b10;
        q_ir.push_back(2'($urandom));
        q_dr.push_back({6'($urandom), $urandom});
        run_scans(1'b0, 1'b0, 1);

        // Random scans with cmd_valid noise while busy
        for (int i = 0; i < 3; i++) begin
            ir_out_drv = 2'($urandom);
            q_ir.push_back(2'($urandom));
            q_dr.push_back({6'($urandom), $urandom});
            run_scans(1'b0, 1'b1, 2);
        end

        // Back-to-back stream
        ir_out_drv = 2'($urandom);
        for (int i = 0; i < 3; i++) begin
            q_ir.push_back(2'($urandom));
            q_dr.push_back({6'($urandom), $urandom});
        end
        run_scans(1'b1, 1'b0, 2);

        // Abort at SDR bit 10 with reset
        tdo_loop = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ir    = 2'b11;
        cmd_dr    = {6'($urandom), $urandom};
        for (int k = 1; k <= 49; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check("at_sdr_bit10", 64'(flags), 64'(exp_flags(49, 165, TD_A, DL_A, cmd_dr)));
        reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        reset_n  = 1'b1;
        rsp_seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (flags[7]) rsp_seen++;
        end
        check("no_rsp_after_abort", 64'(rsp_seen), 64'd0);
        q_ir.push_back(2'b10);
        q_dr.push_back({6'($urandom), $urandom});
        run_scans(1'b0, 1'b0, 0);

        // Small instance: TCK_DIV=1, DR_LEN=2
        sel_b = 1'b1;
        ir_out_drv = 2'($urandom);
        q_ir.push_back(2'b01);
        q_dr.push_back(38'h2);
        run_scans(1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            q_ir.push_back(2'($urandom));
            q_dr.push_back(38'($urandom));
        end
        run_scans(1'b1, 1'b1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
